// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Parametrised multi-read-port integer register file for the rv32i core
//   family. Register 0 is hardwired to zero. After reset, a hardware clear
//   sequence zeroes entries 1..NREGS-1, one per clock. ready then rises and
//   the file starts accepting traffic.
//
// Parameters
//   XLEN   data width of each register
//   NREGS  number of registers (power of two, >= 2)
//   NRD    number of independent combinational read ports (>= 1)
//   AW     derived address width, $clog2(NREGS)
//
// Ports
//   clk      system clock, rising-edge
//   rst      synchronous active-high reset
//   we       write enable; a write happens only when we == REG_WE
//   rd_addr  write address
//   rd_data  write data
//   rs_addr  packed read addresses, port i at [i*AW +: AW]
//   rs_data  packed read data, port i at [i*XLEN +: XLEN]
//   ready    clear sequence finished, file accepts reads and writes
//
// Build option
//   REGFILE_BYPASS_EN  when defined, a qualifying write in the current cycle
//                      is forwarded to any read port that addresses the same
//                      register. Each port is evaluated on its own.
//
// FSM
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_CLEAR | zeroing entry clr_idx each edge, ready low, writes dropped
//   ST_RUN   | normal operation, ready high
// -----------------------------------------------------------------------------

package rv32i;
   typedef enum logic {
      REG_WE_OFF = 1'b0,
      REG_WE     = 1'b1
   } reg_we_e;
endpackage

module regfile_mp
   import rv32i::*;
#(
   parameter  int XLEN  = 32,
   parameter  int NREGS = 32,
   parameter  int NRD   = 2,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  reg_we_e             we,
   input  logic [AW-1:0]       rd_addr,
   input  logic [XLEN-1:0]     rd_data,
   input  logic [NRD*AW-1:0]   rs_addr,
   output logic [NRD*XLEN-1:0] rs_data,
   output logic                ready
);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   localparam logic [AW-1:0] FIRST_IDX = AW'(1);
   localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

   state_e          state_q, state_d;
   logic [AW-1:0]   clr_idx_q, clr_idx_d;
   logic [XLEN-1:0] regs_q [NREGS];

   // Single write port into the array, shared by the clear sequence and the
   // pipeline writeback; the FSM decides which one owns it this cycle.
   logic            wr_en;
   logic [AW-1:0]   wr_idx;
   logic [XLEN-1:0] wr_val;

   logic            user_wr;

   assign ready   = (state_q == ST_RUN);
   assign user_wr = (we == REG_WE) && (rd_addr != '0);

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_CLEAR;
         clr_idx_q <= FIRST_IDX;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next state and write-port arbitration
   // ---------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      wr_en     = 1'b0;
      wr_idx    = rd_addr;
      wr_val    = rd_data;

      case (state_q)
         ST_CLEAR: begin
            wr_en  = 1'b1;
            wr_idx = clr_idx_q;
            wr_val = '0;
            // clr_idx holds at the last entry instead of wrapping to 0.
            if (clr_idx_q == LAST_IDX) begin
               state_d = ST_RUN;
            end else begin
               clr_idx_d = clr_idx_q + 1'b1;
            end
         end
         ST_RUN: begin
            wr_en = user_wr;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Storage. The reset edge itself leaves contents untouched. Entry 0 is
   // never written: the clear starts at 1 and user writes to 0 are masked.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         regs_q[wr_idx] <= wr_val;
      end
   end

   // ---------------------------------------------------------------------
   // Read ports. All lanes are forced to zero until ready. This also keeps
   // stale pre-reset contents hidden while the clear is in progress.
   // ---------------------------------------------------------------------
   always_comb begin
      rs_data = '0;
      for (int i = 0; i < NRD; i++) begin
         if (ready && (rs_addr[i*AW +: AW] != '0)) begin
            rs_data[i*XLEN +: XLEN] = regs_q[rs_addr[i*AW +: AW]];
         end
`ifdef REGFILE_BYPASS_EN
         if (ready && user_wr && (rs_addr[i*AW +: AW] == rd_addr)) begin
            rs_data[i*XLEN +: XLEN] = rd_data;
         end
`else
`endif
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
   import rv32i::*;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 4;
   localparam int AW    = 5;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   reg_we_e             we = REG_WE_OFF;
   logic [AW-1:0]       rd_addr = '0;
   logic [XLEN-1:0]     rd_data = '0;
   logic [NRD*AW-1:0]   rs_addr = '0;
   logic [NRD*XLEN-1:0] rs_data;
   logic                ready;

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
      .clk     (clk),
      .rst     (rst),
      .we      (we),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .rs_addr (rs_addr),
      .rs_data (rs_data),
      .ready   (ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      string               name;
      logic                exp_ready;
      logic [NRD*XLEN-1:0] exp_data;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   logic chk_v = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;

   // Monitor: whenever the driver flags an observation cycle, pop the
   // expected response and compare ready plus every read lane.
   always @(negedge clk) begin
      if (chk_v) begin
         if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL scoreboard_underflow got empty queue want an entry");
         end else begin
            mon_e = sb.pop_front();
            n_assert++;
            if (ready !== mon_e.exp_ready) begin
               n_fail++;
               $display("FAIL %s ready got %0b want %0b", mon_e.name, ready, mon_e.exp_ready);
            end
            for (int i = 0; i < NRD; i++) begin
               n_assert++;
               if (rs_data[i*XLEN +: XLEN] !== mon_e.exp_data[i*XLEN +: XLEN]) begin
                  n_fail++;
                  $display("FAIL %s lane%0d got %h want %h", mon_e.name, i,
                           rs_data[i*XLEN +: XLEN], mon_e.exp_data[i*XLEN +: XLEN]);
               end
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      chk_v = 1'b0;
   endtask

   task automatic expect_rd(input string nm, input logic er, input logic [NRD*XLEN-1:0] ed);
      exp_t e;
      e.name      = nm;
      e.exp_ready = er;
      e.exp_data  = ed;
      sb.push_back(e);
      chk_v = 1'b1;
   endtask

   function automatic logic [NRD*AW-1:0] adr(input int a0, input int a1, input int a2, input int a3);
      return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
   endfunction

   function automatic logic [NRD*XLEN-1:0] dat(input logic [31:0] d0, input logic [31:0] d1,
                                               input logic [31:0] d2, input logic [31:0] d3);
      return {d3, d2, d1, d0};
   endfunction

   task automatic read_group(input string nm, input int b, input logic [31:0] v0,
                             input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] v3);
      rs_addr = adr(b, b + 1, b + 2, b + 3);
      expect_rd(nm, 1'b1, dat(v0, v1, v2, v3));
   endtask

   initial begin
      // Reset held for three edges.
      for (int i = 0; i < 3; i++) begin
         cyc();
         rs_addr = adr(5, 7, 31, 1);
         expect_rd("in_reset", 1'b0, '0);
      end
      rst = 1'b0;

      // Clear: ready after exactly 31 edges. Writes to r3 presented mid-clear.
      for (int k = 1; k <= 31; k++) begin
         cyc();
         we      = (k >= 5 && k <= 10) ? REG_WE : REG_WE_OFF;
         rd_addr = 5'd3;
         rd_data = 32'h55;
         rs_addr = adr(3, 3, 0, k);
         expect_rd("clear", k == 31, '0);
      end

      // Every register zero, including r3.
      for (int g = 0; g < 8; g++) begin
         cyc();
         read_group("zero_init", 4 * g, 0, 0, 0, 0);
      end

      // Basic write / read.
      cyc();
      we = REG_WE; rd_addr = 5'd5; rd_data = 32'hDEADBEEF; rs_addr = adr(0, 0, 0, 0);
      expect_rd("wr_r5_issue", 1'b1, '0);
      cyc();
      we = REG_WE_OFF; rs_addr = adr(5, 5, 0, 0);
      expect_rd("rd_r5", 1'b1, dat(32'hDEADBEEF, 32'hDEADBEEF, 0, 0));

      // x0 protection.
      cyc();
      we = REG_WE; rd_addr = 5'd0; rd_data = 32'h12345678; rs_addr = adr(0, 0, 0, 0);
      expect_rd("x0_same", 1'b1, '0);
      cyc();
      we = REG_WE_OFF;
      expect_rd("x0_after", 1'b1, '0);

      // Same-cycle read of write target.
      cyc();
      we = REG_WE; rd_addr = 5'd7; rd_data = 32'h11111111; rs_addr = adr(5, 0, 0, 0);
      expect_rd("wr_r7_init", 1'b1, dat(32'hDEADBEEF, 0, 0, 0));
      cyc();
      rd_data = 32'hA5A5A5A5; rs_addr = adr(7, 5, 7, 0);
      expect_rd("same_cycle", 1'b1,
                dat(BYP ? 32'hA5A5A5A5 : 32'h11111111, 32'hDEADBEEF,
                    BYP ? 32'hA5A5A5A5 : 32'h11111111, 0));
      cyc();
      we = REG_WE_OFF; rs_addr = adr(7, 7, 5, 0);
      expect_rd("after_write", 1'b1, dat(32'hA5A5A5A5, 32'hA5A5A5A5, 32'hDEADBEEF, 0));

      // Fill r1..r31 with their index.
      for (int r = 1; r <= 31; r++) begin
         cyc();
         we = REG_WE; rd_addr = AW'(r); rd_data = 32'(r); rs_addr = adr(0, 0, 0, 0);
         expect_rd("fill", 1'b1, '0);
      end
      cyc();
      we = REG_WE_OFF;
      expect_rd("fill_end", 1'b1, '0);
      for (int g = 0; g < 8; g++) begin
         cyc();
         read_group("fill_rd", 4 * g, 4 * g, 4 * g + 1, 4 * g + 2, 4 * g + 3);
      end

      // Reset pulse while in RUN.
      cyc();
      rst = 1'b1; rs_addr = adr(1, 2, 30, 31);
      expect_rd("rst_pre_edge", 1'b1, dat(1, 2, 30, 31));
      cyc();
      rst = 1'b0;
      expect_rd("rst_run", 1'b0, '0);

      // Ten clear edges, then a one-cycle reset mid-clear.
      for (int k = 1; k <= 10; k++) begin
         cyc();
         rs_addr = adr(11, 20, 31, k);
         expect_rd("reclear", 1'b0, '0);
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      expect_rd("rst_mid", 1'b0, '0);

      for (int k = 1; k <= 31; k++) begin
         cyc();
         rs_addr = adr(11, 20, 31, k);
         expect_rd("reclear_full", k == 31, '0);
      end

      for (int g = 0; g < 8; g++) begin
         cyc();
         read_group("zero_final", 4 * g, 0, 0, 0, 0);
      end

      cyc();
      cyc();
      n_assert++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain got %0d entries left want 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file for the rv32i core family; successor to the fixed 32x32, 2-read-port register file.
- Generalised in data width, register count and number of read ports.
- Adds a synchronous hardware clear sequence after reset, a ready indication, and optional same-cycle write-to-read forwarding.
- Sits between decode (read addresses) and writeback (write port); the pipeline must not issue reads or writes until ready is high.

Parameters:
XLEN, 32, data width of each register in bits
NREGS, 32, number of architectural registers; power of two, >= 2; register 0 is hardwired zero
NRD, 2, number of independent read ports, >= 1
AW, $clog2(NREGS), register address width (derived; do not override)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
we  input  reg_we_e  write enable from package rv32i; a write occurs only when we == REG_WE
rd_addr  input  AW  write address
rd_data  input  XLEN  write data
rs_addr  input  NRD*AW  packed read addresses; port i uses bits [i*AW +: AW]
rs_data  output  NRD*XLEN  packed read data; port i uses bits [i*XLEN +: XLEN]
ready  output  1  high when the clear sequence is complete and the file accepts traffic

Behaviour:
- Storage: NREGS x XLEN flops. Entry 0 is never written and always reads 0.
- Reads: combinational, zero latency, fully independent per port. Any number of ports may address the same register.
- Writes: committed on a clock edge when we == REG_WE, rd_addr != 0, ready == 1 and rst == 0. A write to address 0 is silently dropped.
- State machine: two states, CLEAR and RUN.
  - rst == 1, in any state: next state CLEAR, clr_idx <= 1, ready <= 0. Register contents are not modified on the reset edge itself.
  - CLEAR with rst == 0: regs[clr_idx] <= 0 and clr_idx <= clr_idx + 1. When clr_idx == NREGS-1, that entry is cleared and the next state is RUN.
  - RUN: stays in RUN until rst is asserted.
- Clear timing: exactly NREGS-1 clock edges with rst low. ready rises after the edge that clears entry NREGS-1 (31 edges for the default).
- Reset while in CLEAR restarts the sequence at entry 1.
- Reset while in RUN drops ready and re-clears all entries.
- While ready == 0:
  - every rs_data lane outputs 0, regardless of address;
  - writes are ignored, not queued.
- Reset values: ready = 0, state = CLEAR, clr_idx = 1. rs_data = 0 on all lanes while in reset.
- Simultaneous write and read of the same register without bypass: the read returns the old value; the new value is visible from the next cycle.
- clr_idx is AW bits wide. It never wraps, because the FSM leaves CLEAR at NREGS-1.
- No X may propagate to rs_data after ready rises. All entries are defined by the clear sequence.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: for each read port i, if we == REG_WE, ready == 1, rd_addr != 0 and rs_addr[i] == rd_addr, then rs_data[i] = rd_data in the same cycle (write-through forwarding). Forwarding is evaluated independently per port.
- Undefined: no forwarding; reads always return the stored value, as described under Behaviour.

Test Plan:
- Reset then clear: hold rst 3 cycles, then release -> ready = 0 for exactly 31 edges, then 1. All 32 registers read 0 on NRD = 4 ports.
- Basic write/read: after ready, write 0xDEADBEEF to r5 -> next cycle rs_addr port 0 = 5, port 1 = 5 -> both read 0xDEADBEEF.
- x0 protection: write 0x12345678 to r0 -> every port addressing r0 reads 0x00000000.
- Same-cycle read of write target: write 0xA5A5A5A5 to r7 while port 0 reads r7 (old value 0x11111111) -> port 0 shows 0x11111111 without REGFILE_BYPASS_EN and 0xA5A5A5A5 with it. Next cycle it shows 0xA5A5A5A5 in both builds.
- Reset mid-clear: assert rst for 1 cycle after 10 clear edges -> ready rises 31 edges after rst is released again.
- Reset in RUN: fill r1..r31 with their index values, pulse rst -> ready = 0 and reads return 0 during clear. After ready, all registers read 0.
- Writes during clear: present we = REG_WE, r3 = 0x55 while ready = 0 -> after ready, r3 reads 0.
